// File: rtl/timer_target.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | timer_target: bus-target interval timer with one-shot/periodic down-count  |
// | Optional prescaler enabled by defining TIMER_PRESCALER_EN.                 |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module timer_target #(
    parameter int counter_width = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [31:0] address,
    input  logic [3:0]  wstrobe,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        irq
);

    localparam logic [2:0] c_addr_ctrl     = 3'd0;
    localparam logic [2:0] c_addr_limit    = 3'd1;
    localparam logic [2:0] c_addr_count    = 3'd2;
    localparam logic [2:0] c_addr_status   = 3'd3;
    localparam logic [2:0] c_addr_prescale = 3'd4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                     r_en;
    logic                     r_irq_en;
    logic                     r_periodic;
    logic                     r_event;
    logic [counter_width-1:0] r_limit;
    logic [counter_width-1:0] r_count;
    logic [31:0]              r_rdata;

    logic        w_access;
    logic        w_write;
    logic        w_wr_ctrl;
    logic        w_wr_limit;
    logic        w_wr_count;
    logic        w_wr_status;
    logic        w_tick;
    logic        w_expire;
    logic        w_clear_event;
    logic [31:0] w_wmask;
    logic [31:0] w_limit_new;
    logic [31:0] w_count_new;
    logic [2:0]  w_ctrl_new;
    logic [31:0] w_read_value;
    logic        w_unused;

    // ---------------------------------------------------------------- response FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_access     = 1'b0;
        ready        = 1'b0;
        case (r_state)
            IDLE: begin
                if (valid) begin
                    w_access     = 1'b1;
                    w_state_next = ACK;
                end
            end
            ACK: begin
                ready        = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- write decode
    assign w_write       = w_access && (wstrobe != 4'b0000);
    assign w_wr_ctrl     = w_write && (address[4:2] == c_addr_ctrl);
    assign w_wr_limit    = w_write && (address[4:2] == c_addr_limit);
    assign w_wr_count    = w_write && (address[4:2] == c_addr_count);
    assign w_wr_status   = w_write && (address[4:2] == c_addr_status);
    assign w_clear_event = w_wr_status && wstrobe[0] && wdata[0];

    assign w_wmask     = {{8{wstrobe[3]}}, {8{wstrobe[2]}}, {8{wstrobe[1]}}, {8{wstrobe[0]}}};
    assign w_limit_new = (32'(r_limit) & ~w_wmask) | (wdata & w_wmask);
    assign w_count_new = (32'(r_count) & ~w_wmask) | (wdata & w_wmask);
    assign w_ctrl_new  = wstrobe[0] ? wdata[2:0] : {r_periodic, r_irq_en, r_en};

    // ---------------------------------------------------------------- tick source
`ifdef TIMER_PRESCALER_EN
    logic [15:0] r_prescale;
    logic [15:0] r_psc_cnt;
    logic        w_wr_prescale;

    assign w_wr_prescale = w_write && (address[4:2] == c_addr_prescale);
    assign w_tick        = r_en && (r_psc_cnt == r_prescale);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prescale <= 16'h0000;
        end else if (w_wr_prescale) begin
            r_prescale <= (r_prescale & ~w_wmask[15:0]) | (wdata[15:0] & w_wmask[15:0]);
        end
    end

    // Prescale counter sits at 0 while disabled so the first tick lands PRESCALE+1 cycles after enable.
    always_ff @(posedge clk) begin
        if (reset || !r_en || w_tick) begin
            r_psc_cnt <= 16'h0000;
        end else begin
            r_psc_cnt <= r_psc_cnt + 16'h0001;
        end
    end
`else
    assign w_tick = r_en;
`endif

    assign w_expire = w_tick && (r_count == '0);

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en       <= 1'b0;
            r_irq_en   <= 1'b0;
            r_periodic <= 1'b0;
        end else if (w_wr_ctrl) begin
            {r_periodic, r_irq_en, r_en} <= w_ctrl_new;
        end else if (w_expire && !r_periodic) begin
            r_en <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_limit <= '0;
        end else if (w_wr_limit) begin
            r_limit <= w_limit_new[counter_width-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_wr_count) begin
            r_count <= w_count_new[counter_width-1:0];
        end else if (w_tick) begin
            if (r_count != '0) begin
                r_count <= r_count - counter_width'(1);
            end else if (r_periodic) begin
                r_count <= r_limit;
            end
        end
    end

    // Hardware expiry takes priority over a simultaneous write-1-to-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_event <= 1'b0;
        end else if (w_expire) begin
            r_event <= 1'b1;
        end else if (w_clear_event) begin
            r_event <= 1'b0;
        end
    end

    // ---------------------------------------------------------------- read path
    always_comb begin
        w_read_value = 32'h0000_0000;
        case (address[4:2])
            c_addr_ctrl:     w_read_value = {29'd0, r_periodic, r_irq_en, r_en};
            c_addr_limit:    w_read_value = 32'(r_limit);
            c_addr_count:    w_read_value = 32'(r_count);
            c_addr_status:   w_read_value = {31'd0, r_event};
`ifdef TIMER_PRESCALER_EN
            c_addr_prescale: w_read_value = {16'd0, r_prescale};
`endif
            default:         w_read_value = 32'h0000_0000;
        endcase
    end

    // Captured from pre-write state; non-zero only during the ACK cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= 32'h0000_0000;
        end else if (w_access) begin
            r_rdata <= w_read_value;
        end else begin
            r_rdata <= 32'h0000_0000;
        end
    end

    assign rdata = r_rdata;
    assign irq   = r_event && r_irq_en;

    assign w_unused = ^{address[31:5], address[1:0], w_limit_new, w_count_new};

endmodule
`default_nettype wire

// File: tb/tb_timer_target.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_timer_target: directed vector bench for timer_target                    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_timer_target;

    logic        clk;
    logic        reset;
    logic        valid;
    logic [31:0] address;
    logic [3:0]  wstrobe;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        irq;

    int checks;
    int errors;

    timer_target #(.counter_width(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .valid   (valid),
        .address (address),
        .wstrobe (wstrobe),
        .wdata   (wdata),
        .rdata   (rdata),
        .ready   (ready),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam logic [31:0] c_ctrl     = 32'h00;
    localparam logic [31:0] c_limit    = 32'h04;
    localparam logic [31:0] c_count    = 32'h08;
    localparam logic [31:0] c_status   = 32'h0C;
    localparam logic [31:0] c_prescale = 32'h10;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete access starting in an idle cycle; returns in the idle cycle after ACK.
    task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       output logic [31:0] rd);
        valid   = 1'b1;
        address = a;
        wstrobe = s;
        wdata   = d;
        check("ready_before_ack", {31'd0, ready}, 32'd0);
        step();
        check("ready_in_ack", {31'd0, ready}, 32'd1);
        rd      = rdata;
        valid   = 1'b0;
        wstrobe = 4'b0000;
        step();
        check("ready_after_ack", {31'd0, ready}, 32'd0);
        check("rdata_after_ack", rdata, 32'd0);
    endtask

    vec_t        vecs[$];
    logic [31:0] rd;

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        valid   = 1'b0;
        address = 32'd0;
        wstrobe = 4'b0000;
        wdata   = 32'd0;
        repeat (3) step();
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;
        step();

        // ---------------- register map vectors
        for (int i = 0; i < 8; i++) begin
            vecs.push_back('{32'(i * 4), 4'b0000, 32'd0, 32'd0});
        end
        vecs.push_back('{c_limit, 4'b0101, 32'h1234_5678, 32'h0000_0000});
        vecs.push_back('{c_limit, 4'b0000, 32'd0,         32'h0034_0078});
        vecs.push_back('{32'h14,  4'b1111, 32'hFFFF_FFFF, 32'h0000_0000});
        vecs.push_back('{32'h14,  4'b0000, 32'd0,         32'h0000_0000});
        vecs.push_back('{32'h1C,  4'b1111, 32'hFFFF_FFFF, 32'h0000_0000});
        vecs.push_back('{32'h1C,  4'b0000, 32'd0,         32'h0000_0000});
        vecs.push_back('{c_ctrl,  4'b1111, 32'hFFFF_FFF8, 32'h0000_0000});
        vecs.push_back('{c_ctrl,  4'b0000, 32'd0,         32'h0000_0000});
        vecs.push_back('{c_limit, 4'b1010, 32'hAABB_CCDD, 32'h0034_0078});
        vecs.push_back('{c_limit, 4'b0000, 32'd0,         32'hAA34_CC78});
        vecs.push_back('{32'hFFFF_FF07, 4'b0000, 32'd0,   32'hAA34_CC78});

        foreach (vecs[i]) begin
            bus(vecs[i].addr, vecs[i].strb, vecs[i].data, rd);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_irq", i), {31'd0, irq}, 32'd0);
        end

        // ---------------- periodic mode: LIMIT=2 -> event every 3 ticks
        bus(c_limit, 4'b1111, 32'd2, rd);
        bus(c_count, 4'b1111, 32'd0, rd);
        bus(c_ctrl,  4'b1111, 32'd7, rd);
        check("per_irq_immediate", {31'd0, irq}, 32'd1);
        bus(c_status, 4'b0001, 32'd1, rd);
        check("per_irq_cleared1", {31'd0, irq}, 32'd0);
        step();
        check("per_irq_again1", {31'd0, irq}, 32'd1);
        bus(c_status, 4'b0001, 32'd1, rd);
        check("per_irq_cleared2", {31'd0, irq}, 32'd0);
        step();
        check("per_irq_again2", {31'd0, irq}, 32'd1);
        bus(c_status, 4'b0001, 32'd1, rd);
        check("per_irq_cleared3", {31'd0, irq}, 32'd0);
        // This clear lands on the same edge as the hardware set; the set wins.
        bus(c_status, 4'b0001, 32'd1, rd);
        check("per_set_beats_clear", {31'd0, irq}, 32'd1);
        bus(c_status, 4'b0001, 32'd0, rd);
        check("w0_status_rdata", rd, 32'd1);
        check("w0_no_clear", {31'd0, irq}, 32'd1);
        bus(c_ctrl, 4'b1111, 32'd0, rd);
        check("ctrl_read_periodic", rd, 32'd7);
        check("irq_masked", {31'd0, irq}, 32'd0);

        // ---------------- back-to-back store then fetch, valid held high
        valid   = 1'b1;
        address = c_count;
        wstrobe = 4'b1111;
        wdata   = 32'h0000_0055;
        check("b2b_ready_n", {31'd0, ready}, 32'd0);
        step();
        check("b2b_ready_n1", {31'd0, ready}, 32'd1);
        wstrobe = 4'b0000;
        step();
        check("b2b_ready_n2", {31'd0, ready}, 32'd0);
        check("b2b_rdata_n2", rdata, 32'd0);
        step();
        check("b2b_ready_n3", {31'd0, ready}, 32'd1);
        check("b2b_rdata_n3", rdata, 32'h0000_0055);
        valid = 1'b0;
        step();
        check("b2b_ready_n4", {31'd0, ready}, 32'd0);

        // ---------------- one-shot: COUNT=3 -> event on the 4th tick after enable
        bus(c_status, 4'b0001, 32'd1, rd);
        bus(c_count, 4'b1111, 32'd3, rd);
        bus(c_ctrl,  4'b1111, 32'd3, rd);
        check("os_irq_0", {31'd0, irq}, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("os_irq_%0d", i), {31'd0, irq}, (i == 3) ? 32'd1 : 32'd0);
        end
        repeat (4) step();
        bus(c_ctrl, 4'b0000, 32'd0, rd);
        check("os_ctrl_en_cleared", rd, 32'd2);
        bus(c_count, 4'b0000, 32'd0, rd);
        check("os_count_stays0", rd, 32'd0);
        bus(c_status, 4'b0000, 32'd0, rd);
        check("os_status_event", rd, 32'd1);

`ifdef TIMER_PRESCALER_EN
        // ---------------- prescaler: PRESCALE=3, COUNT=1 -> irq 8 cycles after enable
        bus(c_status,   4'b0001, 32'd1, rd);
        bus(c_prescale, 4'b1111, 32'd3, rd);
        bus(c_count,    4'b1111, 32'd1, rd);
        bus(c_ctrl,     4'b1111, 32'd3, rd);
        check("psc_irq_0", {31'd0, irq}, 32'd0);
        for (int i = 1; i <= 7; i++) begin
            step();
            check($sformatf("psc_irq_%0d", i), {31'd0, irq}, (i == 7) ? 32'd1 : 32'd0);
        end
        bus(c_prescale, 4'b0000, 32'd0, rd);
        check("psc_readback", rd, 32'd3);
`else
        bus(c_prescale, 4'b1111, 32'hFFFF_FFFF, rd);
        bus(c_prescale, 4'b0000, 32'd0, rd);
        check("psc_absent_reads0", rd, 32'd0);
`endif

        // ---------------- reset during ACK aborts the access
        check("pre_reset_irq", {31'd0, irq}, 32'd1);
        valid   = 1'b1;
        address = c_ctrl;
        wstrobe = 4'b0000;
        step();
        check("abort_ack_ready", {31'd0, ready}, 32'd1);
        reset = 1'b1;
        valid = 1'b0;
        step();
        check("abort_ready", {31'd0, ready}, 32'd0);
        check("abort_rdata", rdata, 32'd0);
        check("abort_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;
        step();
        check("abort_ready_later", {31'd0, ready}, 32'd0);
        bus(c_ctrl, 4'b0000, 32'd0, rd);
        check("post_reset_ctrl", rd, 32'd0);
        bus(c_limit, 4'b0000, 32'd0, rd);
        check("post_reset_limit", rd, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
